// File: rtl/msg_to_pkt_queue.sv
// Message-to-packet queue: gathers a head flit plus data chunks into FIFO slots and presents the oldest as a packet.
// Optional MSG_QUEUE_OVERFLOW_FLAG_EN makes overflow_o a sticky dropped-chunk flag (otherwise tied low).
module msg_to_pkt_queue #(
  parameter int N_BITS_POINTER      = 3,
  parameter int N_BITS_BURST_LENGHT = 7,
  parameter int FLIT_WIDTH          = 8,
  parameter int BUS_DATA_WIDTH      = FLIT_WIDTH,
  parameter int MAX_BURST_LENGHT    = 4,
  parameter int MAX_PACKET_LENGHT   = 5
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    message_start_i,
  input  logic [FLIT_WIDTH-1:0]                   head_i,
  input  logic [BUS_DATA_WIDTH-1:0]               data_i,
  input  logic                                    data_valid_i,
  input  logic                                    last_i,
  input  logic                                    abort_i,
  output logic                                    ready_o,
  output logic                                    r_msg_to_pkt_o,
  input  logic                                    g_msg_to_pkt_i,
  output logic [MAX_PACKET_LENGHT*FLIT_WIDTH-1:0] out_link_o,
  output logic [MAX_PACKET_LENGHT-1:0]            out_sel_o,
  output logic                                    overflow_o
);
  localparam int QUEUE_WIDTH = 1 << N_BITS_POINTER;
  typedef logic [N_BITS_POINTER-1:0]      ptr_t;
  typedef logic [N_BITS_BURST_LENGHT-1:0] cnt_t;
  typedef enum logic {S_IDLE, S_FILL} state_t;
  localparam cnt_t MAX_CNT = cnt_t'(MAX_BURST_LENGHT);

  state_t state_q, state_d;
  cnt_t   count_q, count_d;
  ptr_t   head_pointer_r, head_pointer_d;
  ptr_t   tail_pointer_r, tail_pointer_d;
  logic [QUEUE_WIDTH-1:0] valid_q, valid_d;

  // Slot storage carries no reset; valid_q alone says whether a slot means anything.
  logic [QUEUE_WIDTH-1:0][FLIT_WIDTH-1:0]                       head_mem;
  logic [QUEUE_WIDTH-1:0][MAX_BURST_LENGHT-1:0][FLIT_WIDTH-1:0] data_mem;
  cnt_t [QUEUE_WIDTH-1:0]                                       cnt_mem;

  logic rdy, store_head, store_chunk, commit, take, drop;

  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == ptr_t'(QUEUE_WIDTH-1)) ? '0 : p + 1'b1;
  endfunction

  assign drop = (state_q == S_FILL) && !abort_i && data_valid_i && (count_q == MAX_CNT);
  assign take = g_msg_to_pkt_i && valid_q[head_pointer_r];

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    rdy         = 1'b1;
    store_head  = 1'b0;
    store_chunk = 1'b0;
    commit      = 1'b0;
    case (state_q)
      S_IDLE: begin
        rdy = !valid_q[tail_pointer_r];
        if (message_start_i && rdy) begin
          store_head = 1'b1;
          count_d    = '0;
          if (last_i) commit  = 1'b1;
          else        state_d = S_FILL;
        end
      end
      S_FILL: begin
        if (abort_i) begin
          state_d = S_IDLE;
          count_d = '0;
        end else if (data_valid_i) begin
          if (!drop) begin
            store_chunk = 1'b1;
            count_d     = count_q + 1'b1;
          end
          if (last_i) begin
            commit  = 1'b1;
            state_d = S_IDLE;
            count_d = '0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Commit targets the tail slot (always invalid while filling), grant the valid head slot: never the same slot.
  always_comb begin
    valid_d        = valid_q;
    head_pointer_d = head_pointer_r;
    tail_pointer_d = tail_pointer_r;
    if (take) begin
      valid_d[head_pointer_r] = 1'b0;
      head_pointer_d          = ptr_inc(head_pointer_r);
    end
    if (commit) begin
      valid_d[tail_pointer_r] = 1'b1;
      tail_pointer_d          = ptr_inc(tail_pointer_r);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      count_q        <= '0;
      valid_q        <= '0;
      head_pointer_r <= '0;
      tail_pointer_r <= '0;
    end else begin
      state_q        <= state_d;
      count_q        <= count_d;
      valid_q        <= valid_d;
      head_pointer_r <= head_pointer_d;
      tail_pointer_r <= tail_pointer_d;
    end
  end

  always_ff @(posedge clk) begin
    if (store_head) begin
      head_mem[tail_pointer_r] <= head_i;
      cnt_mem[tail_pointer_r]  <= '0;
    end
    if (store_chunk) begin
      cnt_mem[tail_pointer_r] <= count_q + 1'b1;
      for (int k = 0; k < MAX_BURST_LENGHT; k++)
        if (count_q == cnt_t'(k)) data_mem[tail_pointer_r][k] <= data_i;
    end
  end

`ifdef MSG_QUEUE_OVERFLOW_FLAG_EN
  logic overflow_q;
  always_ff @(posedge clk) begin
    if (rst)       overflow_q <= 1'b0;
    else if (drop) overflow_q <= 1'b1;
  end
  assign overflow_o = overflow_q;
`else
  assign overflow_o = 1'b0;
`endif

  assign ready_o        = rdy;
  assign r_msg_to_pkt_o = valid_q[head_pointer_r];

  // Flit 0 is the head; flit j carries chunk j-1 when j <= stored count.
  cnt_t head_cnt;
  assign head_cnt                   = cnt_mem[head_pointer_r];
  assign out_sel_o[0]               = 1'b1;
  assign out_link_o[FLIT_WIDTH-1:0] = head_mem[head_pointer_r];
  for (genvar j = 1; j < MAX_PACKET_LENGHT; j++) begin : g_flit
    if (j <= MAX_BURST_LENGHT) begin : g_used
      assign out_sel_o[j] = (head_cnt >= cnt_t'(j));
      assign out_link_o[j*FLIT_WIDTH +: FLIT_WIDTH] =
        out_sel_o[j] ? data_mem[head_pointer_r][j-1] : '0;
    end else begin : g_unused
      assign out_sel_o[j]                           = 1'b0;
      assign out_link_o[j*FLIT_WIDTH +: FLIT_WIDTH] = '0;
    end
  end
endmodule

// File: doc/msg_to_pkt_queue.md
MSG_TO_PKT_QUEUE -- requirements
Module: msg_to_pkt_queue

Interface
REQ-001 SHALL have parameter N_BITS_POINTER, default 3, width of the head and tail slot pointers (covers `QUEUE_WIDTH).
REQ-002 SHALL have parameter N_BITS_BURST_LENGHT, default 7, width of the chunk counter (covers `MAX_BURST_LENGHT).
REQ-003 SHALL have port clk  input  1  single clock; all logic on the rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port message_start_i  input  1  bus side announces a new message; head_i is valid.
REQ-006 SHALL have port head_i  input  `FLIT_WIDTH  head (or head_tail) flit of the message.
REQ-007 SHALL have port data_i  input  `BUS_DATA_WIDTH  one message chunk.
REQ-008 SHALL have port data_valid_i  input  1  data_i is valid this cycle.
REQ-009 SHALL have port last_i  input  1  this cycle ends the message; qualified by message_start_i or data_valid_i.
REQ-010 SHALL have port abort_i  input  1  discard the message being filled.
REQ-011 SHALL have port ready_o  output  1  queue accepts message_start_i (IDLE) or data (FILL).
REQ-012 SHALL have port r_msg_to_pkt_o  output  1  request to the output flit buffer; a packet is available.
REQ-013 SHALL have port g_msg_to_pkt_i  input  1  one-cycle grant; the packet on out_link_o is taken this cycle.
REQ-014 SHALL have port out_link_o  output  `MAX_PACKET_LENGHT*`FLIT_WIDTH  packet at the head slot; flit 0 in the LSBs.
REQ-015 SHALL have port out_sel_o  output  `MAX_PACKET_LENGHT  bit j high = flit j valid.
REQ-016 SHALL have port overflow_o  output  1  sticky flag; a chunk was dropped.

Function
REQ-017 SHALL hold `QUEUE_WIDTH slots as a FIFO, each with a valid bit, head flit, data flits and chunk count; head_pointer_r is the oldest slot, tail_pointer_r the slot being filled.
REQ-018 SHALL wrap both pointers from `QUEUE_WIDTH-1 to 0.
REQ-019 SHALL require BUS_DATA_WIDTH == FLIT_WIDTH and MAX_BURST_LENGHT <= MAX_PACKET_LENGHT-1; chunk k is stored as flit k+1.
REQ-020 SHALL implement a receive FSM with states IDLE and FILL.
REQ-021 IDLE: ready_o = !valid[tail]; on message_start_i && ready_o, store head_i, clear the chunk count and enter FILL; if last_i is also high, commit immediately (head-only packet) and stay in IDLE.
REQ-022 IDLE: SHALL ignore message_start_i while ready_o is low (queue full); nothing is stored.
REQ-023 FILL: ready_o = 1; each data_valid_i writes chunk[count] and increments count.
REQ-024 FILL: data_valid_i && last_i SHALL store the chunk, commit the slot and return to IDLE.
REQ-025 Commit: at the next edge valid[tail] = 1 and tail_pointer_r advances.
REQ-026 FILL: abort_i (highest priority) SHALL discard the slot, leave tail_pointer_r and valid unchanged, clear count and return to IDLE.
REQ-027 FILL: data_valid_i with count == `MAX_BURST_LENGHT SHALL drop the chunk and not increment count; last_i still commits.
REQ-028 r_msg_to_pkt_o = valid[head_pointer_r], combinational.
REQ-029 out_link_o and out_sel_o SHALL be driven combinationally from the head slot: bit 0 = 1, bit j = (j <= count), unused flits zero.
REQ-030 g_msg_to_pkt_i while r_msg_to_pkt_o is high SHALL clear valid[head] and advance head_pointer_r at the next edge; a grant with no request SHALL be ignored.
REQ-031 A commit and a grant in the same cycle SHALL both take effect: two different slots, no lost update.
REQ-032 A packet committed at edge N SHALL assert r_msg_to_pkt_o after edge N, giving one-cycle latency.

Reset
REQ-033 On rst: pointers = 0, valid = 0, FSM = IDLE, count = 0, overflow_o = 0, r_msg_to_pkt_o = 0, ready_o = 1.
REQ-034 rst in mid-FILL SHALL discard the partial message; slot contents need no reset.

Configuration
REQ-035 Macro MSG_QUEUE_OVERFLOW_FLAG_EN: if defined, overflow_o is set by REQ-027 drops and cleared only by rst; if undefined, overflow_o is tied to 0 and drops are silent.

Verification
REQ-036 Start with head H plus 3 chunks D0..D2, last on D2 -> next cycle r_msg_to_pkt_o = 1, out_sel_o = 4'b1111 (low bits), flit 0 = H, flit 3 = D2.
REQ-037 Fill all `QUEUE_WIDTH slots with no grant -> ready_o = 0 in IDLE; a further start is ignored; one grant -> ready_o = 1 the next cycle.
REQ-038 Abort after 2 chunks, then a head-only message -> exactly one packet with out_sel_o = ...0001, and tail_pointer_r advanced by 1.
REQ-039 `MAX_BURST_LENGHT+1 chunks -> extra chunk dropped; overflow_o = 1 with the macro, 0 without.
REQ-040 Commit and grant in the same cycle with 1 slot occupied -> occupancy stays 1; pointers wrap from `QUEUE_WIDTH-1 to 0 correctly.
